// File: rtl/sm3_job_ctrl.sv
// rtl/sm3_job_ctrl.sv - SM3 job sequencer: streams message blocks from memory into the core and stores the digest
module sm3_job_ctrl #(
  parameter int AW = 13,
  parameter int DW = 32
) (
  input  logic          AHB_HCLK,
  input  logic          AHB_HRESETN,
  input  logic          ENABLE,
  input  logic [1:0]    CMDR,
  input  logic [AW-1:0] SAR_ADDR,
  input  logic [AW-1:0] DAR_ADDR,
  input  logic [AW-1:0] BSR,
  output logic          MEM_RD,
  output logic          MEM_WR,
  output logic [AW-1:0] MEM_ADDR,
  output logic [DW-1:0] MEM_WDATA,
  input  logic [DW-1:0] MEM_RDATA,
  output logic          CORE_WVALID,
  output logic [3:0]    CORE_WIDX,
  output logic [DW-1:0] CORE_WDATA,
  output logic          CORE_START,
  output logic          CORE_INIT,
  input  logic          CORE_DONE,
  input  logic [255:0]  DIGEST,
  output logic          SET_STR,
  output logic          BUSY
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_KICK  = 3'd2,
    S_WAIT  = 3'd3,
    S_STORE = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t        state_q, state_d;
  // cnt_q: word index in LOAD, digest word in STORE, "pulse already given" marker in DONE
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] src_q, src_d;
  logic [AW-1:0] dst_q, dst_d;
  logic [AW-1:0] blocks_q, blocks_d;
  // init_q: the next CORE_START is the first block of a fresh (IV-initialised) hash
  logic          init_q, init_d;
  logic          cmdr_legal;

  assign cmdr_legal = (CMDR == 2'b01) || (CMDR == 2'b10);

  // State and job-context registers
  always_ff @(posedge AHB_HCLK or negedge AHB_HRESETN) begin
    if (!AHB_HRESETN) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      src_q    <= '0;
      dst_q    <= '0;
      blocks_q <= '0;
      init_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      blocks_q <= blocks_d;
      init_q   <= init_d;
    end
  end

  // Next-state and job-context update; dropping ENABLE mid-job aborts straight to IDLE
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    src_d    = src_q;
    dst_d    = dst_q;
    blocks_d = blocks_q;
    init_d   = init_q;
    case (state_q)
      S_IDLE: begin
        if (ENABLE) begin
          src_d    = SAR_ADDR;
          dst_d    = DAR_ADDR;
          blocks_d = BSR;
          init_d   = (CMDR == 2'b01);
          cnt_d    = '0;
          state_d  = (cmdr_legal && (BSR != '0)) ? S_LOAD : S_DONE;
        end
      end
      S_LOAD: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) state_d = S_KICK;
      end
      S_KICK: begin
        src_d   = src_q + AW'(16);
        init_d  = 1'b0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (CORE_DONE) begin
          blocks_d = blocks_q - AW'(1);
          cnt_d    = '0;
          state_d  = (blocks_q == AW'(1)) ? S_STORE : S_LOAD;
        end
      end
      S_STORE: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd7) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        cnt_d = 4'd1;
        if (!ENABLE) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (!ENABLE && (state_q != S_IDLE) && (state_q != S_DONE)) state_d = S_IDLE;
  end

  // Moore outputs; read data is forwarded to the core one cycle behind its address
  always_comb begin
    MEM_RD      = 1'b0;
    MEM_WR      = 1'b0;
    MEM_ADDR    = '0;
    MEM_WDATA   = '0;
    CORE_WVALID = 1'b0;
    CORE_WIDX   = '0;
    CORE_WDATA  = '0;
    CORE_START  = 1'b0;
    CORE_INIT   = 1'b0;
    SET_STR     = 1'b0;
    BUSY        = (state_q != S_IDLE);
    case (state_q)
      S_LOAD: begin
        MEM_RD   = 1'b1;
        MEM_ADDR = src_q + AW'(cnt_q);
        if (cnt_q != 4'd0) begin
          CORE_WVALID = 1'b1;
          CORE_WIDX   = cnt_q - 4'd1;
          CORE_WDATA  = MEM_RDATA;
        end
      end
      S_KICK: begin
        CORE_WVALID = 1'b1;
        CORE_WIDX   = 4'd15;
        CORE_WDATA  = MEM_RDATA;
        CORE_START  = 1'b1;
        CORE_INIT   = init_q;
      end
      S_STORE: begin
        MEM_WR    = 1'b1;
        MEM_ADDR  = dst_q + AW'(cnt_q);
        MEM_WDATA = DIGEST[255 - 32 * int'(cnt_q[2:0]) -: 32];
      end
      S_DONE: begin
        SET_STR = (cnt_q == 4'd0);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sm3_job_ctrl.sv
// tb/tb_sm3_job_ctrl.sv - self-checking bench for sm3_job_ctrl with memory, SM3 core and job reference models
module tb_sm3_job_ctrl;
  localparam int AW = 13;
  localparam int DW = 32;
  localparam int MEMSZ = 8192;
  localparam logic [255:0] SM3_IV = 256'h7380166f4914b2b9172442d7da8a0600a96f30bc163138aae38dee4db0fb0e4e;
  localparam logic [255:0] ABC_DIG = 256'h66c7f0f462eeedd9d1f2d46bdc10e4e24167c4875cf2f7a2297da02b8f4ba8e0;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic [1:0]    cmdr;
  logic [AW-1:0] sar, dar, bsr;
  logic          mem_rd, mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          core_wvalid;
  logic [3:0]    core_widx;
  logic [DW-1:0] core_wdata;
  logic          core_start, core_init;
  logic          core_done, core_done_m, stray_done;
  logic [255:0]  digest;
  logic          set_str, busy;
  logic [87:0]   outs;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int wr_cnt, wr_last, both_cnt;
  logic [AW-1:0] rd_q[$];
  bit            start_init_q[$];
  int            set_str_q[$];
  logic [31:0]   mem [MEMSZ];
  logic [255:0]  ref_cv;
  logic [255:0]  abc_dig;

  // core model state
  logic [511:0] blk;
  logic [255:0] core_nxt;
  bit           core_pend;
  int           core_dly;

  always #5 clk = ~clk;

  assign core_done = core_done_m | stray_done;
  assign outs = {mem_rd, mem_wr, mem_addr, mem_wdata, core_wvalid, core_widx, core_wdata,
                 core_start, core_init, set_str, busy};

  sm3_job_ctrl #(.AW(AW), .DW(DW)) dut (
    .AHB_HCLK(clk), .AHB_HRESETN(rst_n), .ENABLE(enable), .CMDR(cmdr),
    .SAR_ADDR(sar), .DAR_ADDR(dar), .BSR(bsr),
    .MEM_RD(mem_rd), .MEM_WR(mem_wr), .MEM_ADDR(mem_addr), .MEM_WDATA(mem_wdata),
    .MEM_RDATA(mem_rdata), .CORE_WVALID(core_wvalid), .CORE_WIDX(core_widx),
    .CORE_WDATA(core_wdata), .CORE_START(core_start), .CORE_INIT(core_init),
    .CORE_DONE(core_done), .DIGEST(digest), .SET_STR(set_str), .BUSY(busy)
  );

  function automatic logic [31:0] rol(input logic [31:0] x, input int n);
    int m;
    m = n % 32;
    return (m == 0) ? x : ((x << m) | (x >> (32 - m)));
  endfunction

  function automatic logic [31:0] p0(input logic [31:0] x);
    return x ^ rol(x, 9) ^ rol(x, 17);
  endfunction

  function automatic logic [31:0] p1(input logic [31:0] x);
    return x ^ rol(x, 15) ^ rol(x, 23);
  endfunction

  // SM3 compression function CF(V, B)
  function automatic logic [255:0] sm3_cf(input logic [255:0] v, input logic [511:0] m);
    logic [31:0] w [68];
    logic [31:0] a, b, c, d, e, f, g, h, ss1, ss2, tt1, tt2, t, ff, gg;
    for (int j = 0; j < 16; j++) w[j] = m[511 - 32 * j -: 32];
    for (int j = 16; j < 68; j++)
      w[j] = p1(w[j-16] ^ w[j-9] ^ rol(w[j-3], 15)) ^ rol(w[j-13], 7) ^ w[j-6];
    {a, b, c, d, e, f, g, h} = v;
    for (int j = 0; j < 64; j++) begin
      t   = (j < 16) ? 32'h79cc4519 : 32'h7a879d8a;
      ff  = (j < 16) ? (a ^ b ^ c) : ((a & b) | (a & c) | (b & c));
      gg  = (j < 16) ? (e ^ f ^ g) : ((e & f) | (~e & g));
      ss1 = rol(rol(a, 12) + e + rol(t, j), 7);
      ss2 = ss1 ^ rol(a, 12);
      tt1 = ff + d + ss2 + (w[j] ^ w[j+4]);
      tt2 = gg + h + ss1 + w[j];
      d = c; c = rol(b, 9); b = a; a = tt1;
      h = g; g = rol(f, 19); f = e; e = p0(tt2);
    end
    return v ^ {a, b, c, d, e, f, g, h};
  endfunction

  // Expected chaining value after hashing nb blocks of memory starting at word s
  function automatic logic [255:0] ref_job(input logic [255:0] cv_in, input bit init, input int s, input int nb);
    logic [255:0] cv;
    logic [511:0] m;
    cv = init ? SM3_IV : cv_in;
    for (int bi = 0; bi < nb; bi++) begin
      for (int k = 0; k < 16; k++) m[511 - 32 * k -: 32] = mem[(s + 16 * bi + k) % MEMSZ];
      cv = sm3_cf(cv, m);
    end
    return cv;
  endfunction

  // Memory model (read data one cycle after MEM_RD) and bus monitor
  always @(posedge clk) begin
    if (mem_rd) begin
      mem_rdata <= mem[mem_addr];
      rd_q.push_back(mem_addr);
    end
    if (mem_wr) begin
      mem[mem_addr] = mem_wdata;
      wr_cnt++;
      wr_last = cyc;
    end
    if (mem_rd && mem_wr) both_cnt++;
    if (core_start) start_init_q.push_back(core_init);
    if (set_str) set_str_q.push_back(cyc);
    cyc++;
  end

  // SM3 core model with a random compression time
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_done_m <= 1'b0;
      digest      <= '0;
      core_pend   = 1'b0;
      core_dly    = 0;
    end else begin
      core_done_m <= 1'b0;
      if (core_wvalid) blk[511 - 32 * core_widx -: 32] = core_wdata;
      if (core_start) begin
        core_nxt  = sm3_cf(core_init ? SM3_IV : digest, blk);
        core_pend = 1'b1;
        core_dly  = $urandom_range(1, 6);
      end else if (core_pend) begin
        if (core_dly <= 1) begin
          core_done_m <= 1'b1;
          digest      <= core_nxt;
          core_pend   = 1'b0;
        end else begin
          core_dly--;
        end
      end
    end
  end

  task automatic clear_mon;
    rd_q.delete();
    start_init_q.delete();
    set_str_q.delete();
    wr_cnt = 0;
    wr_last = -1;
    both_cnt = 0;
  endtask

  task automatic fill_rand(input int s, input int n);
    for (int k = 0; k < n; k++) mem[(s + k) % MEMSZ] = $urandom;
  endtask

  // Runs one job to its SET_STR pulse, holds ENABLE a few DONE cycles, then drops it
  task automatic run_job(input logic [1:0] c, input logic [AW-1:0] s, input logic [AW-1:0] d,
                         input logic [AW-1:0] b, input int stray_at, output bit to, output int en_cyc);
    clear_mon();
    @(negedge clk);
    cmdr = c; sar = s; dar = d; bsr = b; enable = 1'b1;
    en_cyc = cyc;
    to = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      stray_done = (i == stray_at);
      if (set_str_q.size() != 0) begin
        to = 1'b0;
        break;
      end
    end
    stray_done = 1'b0;
    repeat (3) @(negedge clk);
    enable = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; enable = 1'b1; cmdr = 2'b01; sar = '0; dar = '0; bsr = 13'd1; stray_done = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (outs !== '0) begin n_bad++; $display("FAIL reset_outs: got %h want 0", outs); end
    enable = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (outs !== '0) begin n_bad++; $display("FAIL idle_outs: got %h want 0", outs); end
  endtask

  task automatic test_abc;
    bit to; int en;
    for (int k = 0; k < 16; k++) mem[16'h100 + k] = 32'h0;
    mem[16'h100] = 32'h61626380;
    mem[16'h10F] = 32'h00000018;
    run_job(2'b01, 13'h100, 13'h200, 13'd1, -1, to, en);
    n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL abc_timeout: got %0d want 0", to); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (mem[16'h200 + i] !== abc_dig[255 - 32 * i -: 32]) begin
        n_bad++; $display("FAIL abc_word%0d: got %h want %h", i, mem[16'h200 + i], abc_dig[255 - 32 * i -: 32]);
      end
    end
    n_cmp++; if (set_str_q.size() !== 1) begin n_bad++; $display("FAIL abc_set_str_count: got %0d want 1", set_str_q.size()); end
    n_cmp++;
    if (((set_str_q.size() > 0) ? set_str_q[0] : -1) !== wr_last + 1) begin
      n_bad++; $display("FAIL abc_set_str_after_write: got cyc %0d want %0d", (set_str_q.size() > 0) ? set_str_q[0] : -1, wr_last + 1);
    end
    n_cmp++; if (wr_cnt !== 8) begin n_bad++; $display("FAIL abc_write_count: got %0d want 8", wr_cnt); end
    n_cmp++;
    if (start_init_q.size() !== 1 || ((start_init_q.size() > 0) ? start_init_q[0] : 1'b0) !== 1'b1) begin
      n_bad++; $display("FAIL abc_start_init: got %0d starts want 1 start with init", start_init_q.size());
    end
    ref_cv = abc_dig;
  endtask

  task automatic test_wrap;
    bit to; int en; int bad; logic [255:0] exp;
    fill_rand(13'h1FF8, 32);
    exp = ref_job(ref_cv, 1'b1, 13'h1FF8, 2);
    run_job(2'b01, 13'h1FF8, 13'h0400, 13'd2, -1, to, en);
    n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL wrap_timeout: got %0d want 0", to); end
    bad = 0;
    for (int k = 0; k < 32; k++)
      if (k >= rd_q.size() || rd_q[k] !== AW'(13'h1FF8 + k)) bad++;
    n_cmp++; if (rd_q.size() !== 32 || bad !== 0) begin n_bad++; $display("FAIL wrap_reads: got %0d reads %0d wrong want 32 reads 0 wrong", rd_q.size(), bad); end
    n_cmp++;
    if (start_init_q.size() !== 2 || start_init_q[0] !== 1'b1 || start_init_q[1] !== 1'b0) begin
      n_bad++; $display("FAIL wrap_init_pattern: got %0d starts want 2 starts init=1,0", start_init_q.size());
    end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (mem[16'h400 + i] !== exp[255 - 32 * i -: 32]) begin
        n_bad++; $display("FAIL wrap_word%0d: got %h want %h", i, mem[16'h400 + i], exp[255 - 32 * i -: 32]);
      end
    end
    ref_cv = exp;
  endtask

  task automatic test_empty;
    logic [1:0] cs [3];
    logic [AW-1:0] bs [3];
    bit to; int en;
    cs[0] = 2'b01; bs[0] = 13'd0;
    cs[1] = 2'b11; bs[1] = 13'd1;
    cs[2] = 2'b00; bs[2] = 13'd3;
    for (int t = 0; t < 3; t++) begin
      run_job(cs[t], 13'h100, 13'h300, bs[t], -1, to, en);
      n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL empty%0d_timeout: got %0d want 0", t, to); end
      n_cmp++;
      if (rd_q.size() !== 0 || wr_cnt !== 0 || start_init_q.size() !== 0) begin
        n_bad++; $display("FAIL empty%0d_activity: got rd=%0d wr=%0d start=%0d want 0 0 0", t, rd_q.size(), wr_cnt, start_init_q.size());
      end
      // SET_STR is captured at the second rising edge after ENABLE rises
      n_cmp++;
      if (set_str_q.size() !== 1 || ((set_str_q.size() > 0) ? set_str_q[0] : -1) !== en + 1) begin
        n_bad++; $display("FAIL empty%0d_set_str: got %0d pulses at %0d want 1 at %0d", t, set_str_q.size(), (set_str_q.size() > 0) ? set_str_q[0] : -1, en + 1);
      end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL empty%0d_idle: got busy %0d want 0", t, busy); end
    end
  endtask

  task automatic test_random_jobs;
    bit to; int en; int bad; logic [255:0] exp;
    logic [1:0] c; logic [AW-1:0] s, d; int nb; bit init;
    for (int r = 0; r < 4; r++) begin
      init = $urandom_range(0, 1);
      c  = init ? 2'b01 : 2'b10;
      nb = $urandom_range(1, 3);
      s  = AW'($urandom);
      d  = AW'(s + 16 * nb + $urandom_range(0, 100));
      fill_rand(s, 16 * nb);
      exp = ref_job(ref_cv, init, s, nb);
      run_job(c, s, d, AW'(nb), -1, to, en);
      n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL rand%0d_timeout: got %0d want 0", r, to); end
      bad = 0;
      for (int k = 0; k < 16 * nb; k++)
        if (k >= rd_q.size() || rd_q[k] !== AW'(s + k)) bad++;
      n_cmp++; if (rd_q.size() !== 16 * nb || bad !== 0) begin n_bad++; $display("FAIL rand%0d_reads: got %0d reads %0d wrong want %0d", r, rd_q.size(), bad, 16 * nb); end
      bad = 0;
      for (int b = 0; b < start_init_q.size(); b++)
        if (start_init_q[b] !== (init && b == 0)) bad++;
      n_cmp++; if (start_init_q.size() !== nb || bad !== 0) begin n_bad++; $display("FAIL rand%0d_starts: got %0d (%0d bad init) want %0d", r, start_init_q.size(), bad, nb); end
      n_cmp++; if (both_cnt !== 0) begin n_bad++; $display("FAIL rand%0d_rd_wr_overlap: got %0d want 0", r, both_cnt); end
      for (int i = 0; i < 8; i++) begin
        n_cmp++;
        if (mem[(d + i) % MEMSZ] !== exp[255 - 32 * i -: 32]) begin
          n_bad++; $display("FAIL rand%0d_word%0d: got %h want %h", r, i, mem[(d + i) % MEMSZ], exp[255 - 32 * i -: 32]);
        end
      end
      ref_cv = exp;
    end
  endtask

  task automatic test_abort;
    bit to; int en; logic [255:0] exp; logic [AW-1:0] s;
    s = AW'($urandom);
    fill_rand(s, 32);
    exp = ref_job(ref_cv, 1'b1, s, 2);
    clear_mon();
    @(negedge clk);
    cmdr = 2'b01; sar = s; dar = AW'(s + 13'h100); bsr = 13'd2; enable = 1'b1;
    for (int i = 0; i < 10 && !mem_rd; i++) @(negedge clk);
    n_cmp++; if (mem_rd !== 1'b1) begin n_bad++; $display("FAIL abort_load_start: got %0d want 1", mem_rd); end
    repeat (4) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    n_cmp++; if ({busy, mem_rd, core_wvalid} !== 3'b000) begin n_bad++; $display("FAIL abort_idle: got %b want 000", {busy, mem_rd, core_wvalid}); end
    repeat (20) @(negedge clk);
    n_cmp++;
    if (rd_q.size() !== 5 || wr_cnt !== 0 || start_init_q.size() !== 0 || set_str_q.size() !== 0) begin
      n_bad++; $display("FAIL abort_activity: got rd=%0d wr=%0d start=%0d set_str=%0d want 5 0 0 0", rd_q.size(), wr_cnt, start_init_q.size(), set_str_q.size());
    end
    run_job(2'b01, s, AW'(s + 13'h100), 13'd2, -1, to, en);
    n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL restart_timeout: got %0d want 0", to); end
    n_cmp++;
    if (rd_q.size() !== 32 || ((rd_q.size() > 0) ? rd_q[0] : '0) !== s) begin
      n_bad++; $display("FAIL restart_reads: got %0d reads from %h want 32 from %h", rd_q.size(), (rd_q.size() > 0) ? rd_q[0] : '0, s);
    end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (mem[(s + 256 + i) % MEMSZ] !== exp[255 - 32 * i -: 32]) begin
        n_bad++; $display("FAIL restart_word%0d: got %h want %h", i, mem[(s + 256 + i) % MEMSZ], exp[255 - 32 * i -: 32]);
      end
    end
    ref_cv = exp;
  endtask

  task automatic test_stray_done;
    bit to; int en; logic [255:0] exp;
    fill_rand(13'h0800, 16);
    exp = ref_job(ref_cv, 1'b1, 13'h0800, 1);
    run_job(2'b01, 13'h0800, 13'h0900, 13'd1, 2, to, en);
    n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL stray_timeout: got %0d want 0", to); end
    n_cmp++;
    if (rd_q.size() !== 16 || wr_cnt !== 8 || start_init_q.size() !== 1) begin
      n_bad++; $display("FAIL stray_activity: got rd=%0d wr=%0d start=%0d want 16 8 1", rd_q.size(), wr_cnt, start_init_q.size());
    end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (mem[16'h900 + i] !== exp[255 - 32 * i -: 32]) begin
        n_bad++; $display("FAIL stray_word%0d: got %h want %h", i, mem[16'h900 + i], exp[255 - 32 * i -: 32]);
      end
    end
    ref_cv = exp;
  endtask

  task automatic test_reset_store;
    logic [255:0] exp;
    fill_rand(13'h0A00, 16);
    for (int i = 0; i < 8; i++) mem[16'h0B00 + i] = 32'hDEAD0000 + i;
    exp = ref_job(ref_cv, 1'b1, 13'h0A00, 1);
    clear_mon();
    @(negedge clk);
    cmdr = 2'b01; sar = 13'h0A00; dar = 13'h0B00; bsr = 13'd1; enable = 1'b1;
    for (int i = 0; i < 300 && !mem_wr; i++) @(negedge clk);
    n_cmp++; if (mem_wr !== 1'b1) begin n_bad++; $display("FAIL rst_store_reach: got %0d want 1", mem_wr); end
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++; if (outs !== '0) begin n_bad++; $display("FAIL rst_store_outs: got %h want 0", outs); end
    @(negedge clk);
    n_cmp++; if (wr_cnt !== 2) begin n_bad++; $display("FAIL rst_store_writes: got %0d want 2", wr_cnt); end
    n_cmp++;
    if ({mem[16'h0B00], mem[16'h0B01], mem[16'h0B02]} !== {exp[255:224], exp[223:192], 32'hDEAD0002}) begin
      n_bad++; $display("FAIL rst_store_mem: got %h %h %h want %h %h %h", mem[16'h0B00], mem[16'h0B01], mem[16'h0B02], exp[255:224], exp[223:192], 32'hDEAD0002);
    end
    n_cmp++; if (set_str_q.size() !== 0) begin n_bad++; $display("FAIL rst_store_set_str: got %0d want 0", set_str_q.size()); end
    enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_store_idle: got %0d want 0", busy); end
  endtask

  initial begin
    abc_dig = ABC_DIG;
    ref_cv = '0;
    for (int i = 0; i < MEMSZ; i++) mem[i] = 32'h0;
    clear_mon();
    test_reset();
    test_abc();
    test_wrap();
    test_empty();
    test_random_jobs();
    test_abort();
    test_stray_done();
    test_reset_store();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
